// File: rtl/mem_stage_unit.sv
// mem_stage_unit: MEM pipeline stage with a req/ready data port, a wait-state timeout, branch resolve and the MEM/WB latch
module mem_stage_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  WB,
    input  logic [2:0]  M,
    input  logic [7:0]  jump_address,
    input  logic [7:0]  ALU_status,
    input  logic [31:0] ALU_result,
    input  logic [31:0] write_data,
    input  logic [4:0]  RegDst_address,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        pc_src,
    output logic [7:0]  branch_target,
    output logic [1:0]  wb_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  reg_dst_out,
    output logic [1:0]  mem_err
);
    typedef enum logic {IDLE, WAIT} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    state_t     state;
    logic [7:0] count;
    logic       op, misaligned, access, abort, complete;
    logic       unused_status;
    assign unused_status = ^ALU_status[7:1];
    assign op            = M[1] | M[0];
    assign misaligned    = op & (ALU_result[1:0] != 2'b00);
    assign access        = op & ~misaligned;
    // Request is dropped the instant reset asserts, even mid-access
    assign mem_req       = rst_n & ((state == WAIT) | access);
    assign abort         = (state == WAIT) & ~mem_ready & (count == LAST);
    assign stall         = mem_req & ~mem_ready & ~abort;
    assign complete      = mem_req & mem_ready;
    assign mem_we        = M[0];
    assign mem_addr      = ALU_result;
    assign mem_wdata     = write_data;
    assign pc_src        = M[2] & ALU_status[0];
    assign branch_target = jump_address;
    // Access sequencer: count holds the number of request cycles already spent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else if (state == IDLE) begin
            if (access & ~mem_ready) begin
                state <= WAIT;
                count <= 8'd1;
            end
        end else if (mem_ready | abort) begin
            state <= IDLE;
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end
    // MEM/WB latch advances whenever upstream is not frozen; aborts and misaligned ops become bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_out         <= '0;
            read_data_out  <= '0;
            alu_result_out <= '0;
            reg_dst_out    <= '0;
            mem_err        <= '0;
        end else if (stall) begin
            mem_err <= '0;
        end else begin
            wb_out         <= (abort | misaligned) ? 2'b00 : WB;
            alu_result_out <= ALU_result;
            reg_dst_out    <= RegDst_address;
            read_data_out  <= (complete & ~M[0]) ? mem_rdata : read_data_out;
            mem_err        <= {misaligned, abort};
        end
    end
endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
- Consumer side of the EX/MEM pipeline latch: takes the latched WB/M control, ALU result, store data and destination register, and performs the data-memory access.
- Drives a req/ready data-memory port and stalls the upstream pipeline while an access is outstanding.
- Resolves the branch decision and loads the MEM/WB outputs: WB control, load data, ALU result and destination register.

Parameters:
- TIMEOUT, 16: maximum number of request cycles (including the first) before an access is aborted; legal range 2..255.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- WB  in  2  EX/MEM latched write-back control; WB[1]=RegWrite, WB[0]=MemtoReg
- M  in  3  EX/MEM latched memory control; M[2]=Branch, M[1]=MemRead, M[0]=MemWrite
- jump_address  in  8  branch target from EX/MEM
- ALU_status  in  8  ALU flags; ALU_status[0]=zero
- ALU_result  in  32  address for loads/stores, pass-through value otherwise
- write_data  in  32  store data
- RegDst_address  in  5  destination register
- mem_req  out  1  data-memory request
- mem_we  out  1  1=write, 0=read; valid while mem_req=1
- mem_addr  out  32  equals ALU_result
- mem_wdata  out  32  equals write_data
- mem_ready  in  1  memory completes the access in a cycle where mem_req=1 and mem_ready=1; mem_rdata is valid that same cycle
- mem_rdata  in  32  read data
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM latches this cycle
- pc_src  out  1  take branch
- branch_target  out  8  equals jump_address
- wb_out  out  2  MEM/WB control, registered
- read_data_out  out  32  MEM/WB load data, registered
- alu_result_out  out  32  MEM/WB ALU result, registered
- reg_dst_out  out  5  MEM/WB destination register, registered
- mem_err  out  2  registered one-cycle pulse; bit0=timeout, bit1=misaligned

Behaviour:
- Reset (async, rst_n=0):
  - All registered outputs (wb_out, read_data_out, alu_result_out, reg_dst_out, mem_err) are 0.
  - FSM goes to IDLE and the wait counter is cleared to 0.
  - mem_req=0 and stall=0 while reset is asserted.
  - Reset asserted mid-access drops the request immediately; no MEM/WB update occurs.
- Decode:
  - op = M[1] | M[0]; MemWrite has priority if both are set (mem_we = M[0]).
  - misaligned = op & (ALU_result[1:0] != 0).
  - access = op & ~misaligned.
- Branch:
  - pc_src = M[2] & ALU_status[0], combinational; branch_target = jump_address.
  - Neither is affected by stall.
- FSM states: IDLE, WAIT.
  - IDLE, access=0: no request. Next edge loads MEM/WB. Latency is 1 cycle.
  - IDLE, access=1: mem_req=1 combinationally, count=0.
    - If mem_ready=1: complete this cycle, stay in IDLE.
    - Else: stall=1, go to WAIT with count=1.
  - WAIT: mem_req=1; inputs are held stable by stall.
    - mem_ready=1: complete, go to IDLE, count cleared to 0.
    - mem_ready=0 and count==TIMEOUT-1: abort, go to IDLE, count cleared to 0.
    - Otherwise: count increments.
  - stall = mem_req & ~mem_ready & ~abort, so upstream advances in both the complete cycle and the abort cycle.
- MEM/WB load: occurs on every edge where stall=0.
  - Normal: wb_out=WB, alu_result_out=ALU_result, reg_dst_out=RegDst_address.
  - read_data_out=mem_rdata for a completed read; otherwise it holds its previous value.
  - Completed write: WB is passed through unchanged.
  - Abort: wb_out=0 (bubble), mem_err=2'b01.
  - Misaligned: no request is issued, wb_out=0, mem_err=2'b10; completes in 1 cycle, no stall.
  - mem_err is 0 on all other loads.
- While stall=1: MEM/WB outputs hold and mem_err=0.
- mem_ready asserted while mem_req=0 is ignored.

Test Plan:
- Reset, then R-type pass-through: WB=2'b10, M=0, ALU_result=32'h1234, RegDst_address=5 -> next edge wb_out=2'b10, alu_result_out=32'h1234, reg_dst_out=5, stall never asserted.
- Load with 3-cycle wait: M=3'b010, ALU_result=32'h40, mem_ready high in 3rd request cycle with mem_rdata=32'hDEADBEEF -> stall=1 for exactly 2 cycles, then read_data_out=32'hDEADBEEF, mem_err=0.
- Store with ready in the first cycle: M=3'b001, write_data=32'hA5A5A5A5, mem_ready=1 -> mem_we=1, mem_wdata=32'hA5A5A5A5, stall=0, 1-cycle latency.
- Timeout (TIMEOUT=4): load, mem_ready held 0 -> mem_req high for exactly 4 cycles, stall high for 3, then wb_out=0 and mem_err=2'b01 for one cycle.
- Misaligned store to ALU_result=32'h42 -> mem_req stays 0, wb_out=0, mem_err=2'b10 for one cycle.
- Branch: M=3'b100, ALU_status=8'h01, jump_address=8'h3C -> pc_src=1, branch_target=8'h3C; with ALU_status=8'h00 -> pc_src=0.
- Reset mid-WAIT: rst_n low during 2nd wait cycle -> mem_req and stall drop at once, all registered outputs 0, FSM in IDLE after release.
